wvb_rd_ctrl: RTL and testbench

// - Waveform buffer readout controller, the consumer side of the waveform buffer.
// - Pops one event header from the header FIFO and streams that event's samples out of the buffer RAM.
// - Reads addresses start_addr..stop_addr, wrapping modulo 2^P_ADR_WIDTH.
// - Pulses wvb_rddone once the event is fully consumed; the overflow controller uses this to release buffer space.

---
 rtl/wvb_rd_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_wvb_rd_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wvb_rd_ctrl.sv
// Waveform buffer readout: pops one header, streams start..stop (mod 2^P_ADR_WIDTH), pulses wvb_rddone.
// Latency: pop at T, first read at T+1, first beat at T+2, last beat at T+1+len, rddone at T+2+len.
// Backpressure: 2-entry skid buffer; reads are throttled so in-flight plus buffered words never exceed 2.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   rd_req                           arbiter grant, sampled in IDLE only
//   hdr_empty, hdr_start_addr,
//   hdr_stop_addr, hdr_rdreq         show-ahead header FIFO head and pop pulse
//   wvb_rd_addr, wvb_rd_en,
//   wvb_rd_data                      buffer RAM read port (1-cycle read latency)
//   dout, dout_valid, dout_ready,
//   dout_sop, dout_eop               sample stream, valid/ready handshake
//   wvb_rddone                       one-cycle pulse after the last beat of an event
//   busy                             high outside IDLE
module wvb_rd_ctrl #(
    parameter int P_ADR_WIDTH  = 12,
    parameter int P_DATA_WIDTH = 22
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rd_req,
    input  logic                    hdr_empty,
    input  logic [P_ADR_WIDTH-1:0]  hdr_start_addr,
    input  logic [P_ADR_WIDTH-1:0]  hdr_stop_addr,
    output logic                    hdr_rdreq,
    output logic [P_ADR_WIDTH-1:0]  wvb_rd_addr,
    output logic                    wvb_rd_en,
    input  logic [P_DATA_WIDTH-1:0] wvb_rd_data,
    output logic [P_DATA_WIDTH-1:0] dout,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic                    dout_sop,
    output logic                    dout_eop,
    output logic                    wvb_rddone,
    output logic                    busy
);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic                    sop;
        logic                    eop;
        logic [P_DATA_WIDTH-1:0] dat;
    } beat_t;

    localparam logic [P_ADR_WIDTH-1:0] ADR_ONE  = {{(P_ADR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [P_ADR_WIDTH:0]   LEN_ONE  = {{P_ADR_WIDTH{1'b0}}, 1'b1};
    localparam logic [P_ADR_WIDTH:0]   LEN_FULL = {1'b1, {P_ADR_WIDTH{1'b0}}};

    state_t                 state;
    logic [P_ADR_WIDTH-1:0] rd_ptr;
    logic [P_ADR_WIDTH:0]   remaining;
    logic                   first_rd;

    // Word in flight from the RAM: data shows up on wvb_rd_data this cycle.
    logic                   rd_vld_d;
    logic                   rd_sop_d;
    logic                   rd_eop_d;

    beat_t                  skid0;
    beat_t                  skid1;
    logic [1:0]             skid_cnt;

    logic [P_ADR_WIDTH-1:0] len_mod;
    logic [P_ADR_WIDTH:0]   len;
    beat_t                  ram_beat;
    beat_t                  head;
    logic                   beat_acc;
    logic                   room;
    logic                   issue;
    logic                   last_addr;

    // A modular length of zero can only mean the event fills the whole buffer.
    assign len_mod = hdr_stop_addr - hdr_start_addr + ADR_ONE;
    assign len     = (len_mod == '0) ? LEN_FULL : {1'b0, len_mod};

    assign ram_beat = {rd_sop_d, rd_eop_d, wvb_rd_data};

    // Buffered words go first; an empty buffer lets the RAM word bypass straight
    // to the output so the first beat appears the cycle after its read.
    always_comb begin
        head = '0;
        if (skid_cnt != 2'd0) begin
            head = skid0;
        end else if (rd_vld_d) begin
            head = ram_beat;
        end
    end

    assign dout_valid = (skid_cnt != 2'd0) || rd_vld_d;
    assign dout       = head.dat;
    assign dout_sop   = head.sop;
    assign dout_eop   = head.eop;
    assign beat_acc   = dout_valid && dout_ready;

    // Outstanding words after this cycle's acceptance must stay below 2 before a new read.
    assign room      = ({1'b0, skid_cnt} + {2'b00, rd_vld_d}) < (3'd2 + {2'b00, beat_acc});
    assign issue     = (state == S_STREAM) && room && !rst;
    assign last_addr = (remaining == LEN_ONE);

    assign wvb_rd_en   = issue;
    assign wvb_rd_addr = rd_ptr;
    assign hdr_rdreq   = (state == S_IDLE) && rd_req && !hdr_empty && !rst;
    assign wvb_rddone  = (state == S_DONE);
    assign busy        = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rd_ptr    <= '0;
            remaining <= '0;
            first_rd  <= 1'b0;
            rd_vld_d  <= 1'b0;
            rd_sop_d  <= 1'b0;
            rd_eop_d  <= 1'b0;
            skid0     <= '0;
            skid1     <= '0;
            skid_cnt  <= 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (hdr_rdreq) begin
                        rd_ptr    <= hdr_start_addr;
                        remaining <= len;
                        first_rd  <= 1'b1;
                        state     <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (issue) begin
                        rd_ptr    <= rd_ptr + ADR_ONE;
                        remaining <= remaining - LEN_ONE;
                        first_rd  <= 1'b0;
                        if (last_addr) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (beat_acc && dout_eop) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            rd_vld_d <= issue;
            rd_sop_d <= issue && first_rd;
            rd_eop_d <= issue && last_addr;

            // The throttle guarantees the buffer is never full while a word is in flight.
            case (skid_cnt)
                2'd0: begin
                    if (rd_vld_d && !beat_acc) begin
                        skid0    <= ram_beat;
                        skid_cnt <= 2'd1;
                    end
                end
                2'd1: begin
                    if (rd_vld_d) begin
                        if (beat_acc) begin
                            skid0 <= ram_beat;
                        end else begin
                            skid1    <= ram_beat;
                            skid_cnt <= 2'd2;
                        end
                    end else if (beat_acc) begin
                        skid_cnt <= 2'd0;
                    end
                end
                2'd2: begin
                    if (beat_acc) begin
                        skid0    <= skid1;
                        skid_cnt <= 2'd1;
                    end
                end
                default: begin
                    skid_cnt <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wvb_rd_ctrl.sv
// Directed bench for wvb_rd_ctrl: header FIFO and RAM models, cycle-stamped logs, expected values computed here.
// Latency: every check is relative to the pop cycle, which each test expects at cycle 0.
// Backpressure: dout_ready is held high except for one test using a 50% random pattern.
module tb_wvb_rd_ctrl;

    localparam int AW    = 12;
    localparam int DW    = 22;
    localparam int DEPTH = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rd_req = 1'b0;
    logic          hdr_empty = 1'b1;
    logic [AW-1:0] hdr_start_addr = '0;
    logic [AW-1:0] hdr_stop_addr = '0;
    logic          hdr_rdreq;
    logic [AW-1:0] wvb_rd_addr;
    logic          wvb_rd_en;
    logic [DW-1:0] wvb_rd_data = '0;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready = 1'b1;
    logic          dout_sop;
    logic          dout_eop;
    logic          wvb_rddone;
    logic          busy;

    always #5 clk = ~clk;

    wvb_rd_ctrl #(.P_ADR_WIDTH(AW), .P_DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .rd_req        (rd_req),
        .hdr_empty     (hdr_empty),
        .hdr_start_addr(hdr_start_addr),
        .hdr_stop_addr (hdr_stop_addr),
        .hdr_rdreq     (hdr_rdreq),
        .wvb_rd_addr   (wvb_rd_addr),
        .wvb_rd_en     (wvb_rd_en),
        .wvb_rd_data   (wvb_rd_data),
        .dout          (dout),
        .dout_valid    (dout_valid),
        .dout_ready    (dout_ready),
        .dout_sop      (dout_sop),
        .dout_eop      (dout_eop),
        .wvb_rddone    (wvb_rddone),
        .busy          (busy)
    );

    // RAM contents are a unique function of address so reorders and duplicates show up.
    function automatic logic [DW-1:0] ramf(input int a);
        logic [AW-1:0] aa;
        aa = AW'(a);
        return {aa[9:0] ^ 10'h2a5, aa};
    endfunction

    always @(posedge clk) begin
        if (wvb_rd_en) wvb_rd_data <= ramf(int'(wvb_rd_addr));
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rst_at = -1;
    bit force_rst = 1'b1;
    bit ready_rand = 1'b0;
    int hq_start[$];
    int hq_stop[$];
    int q_pop[$];
    int q_done[$];
    int q_rdaddr[$];
    int q_rdcyc[$];
    int q_beat[$];
    int q_bcyc[$];
    int issued, accepted, maxout, stall_err;
    bit prev_stall;
    logic [DW+2:0] snap;
    logic busy_now;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int out_flags();
        return int'({hdr_rdreq, wvb_rd_en, dout_valid, dout_sop, dout_eop, wvb_rddone, busy});
    endfunction

    // One clock cycle: drive at negedge, observe 1 ns later, log everything.
    task automatic tick();
        @(negedge clk);
        rst       = force_rst || (cyc == rst_at);
        hdr_empty = (hq_start.size() == 0);
        if (hq_start.size() != 0) begin
            hdr_start_addr = AW'(hq_start[0]);
            hdr_stop_addr  = AW'(hq_stop[0]);
        end else begin
            hdr_start_addr = '0;
            hdr_stop_addr  = '0;
        end
        dout_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (hdr_rdreq) begin
            q_pop.push_back(cyc);
            void'(hq_start.pop_front());
            void'(hq_stop.pop_front());
        end
        if (wvb_rd_en) begin
            q_rdaddr.push_back(int'(wvb_rd_addr));
            q_rdcyc.push_back(cyc);
            issued++;
        end
        if (dout_valid && dout_ready) begin
            q_beat.push_back(int'({dout_sop, dout_eop, dout}));
            q_bcyc.push_back(cyc);
            accepted++;
        end
        if (issued - accepted > maxout) maxout = issued - accepted;
        if (prev_stall && ({dout_valid, dout_sop, dout_eop, dout} != snap)) stall_err++;
        prev_stall = dout_valid && !dout_ready;
        snap       = {dout_valid, dout_sop, dout_eop, dout};
        if (wvb_rddone) q_done.push_back(cyc);
        busy_now = busy;
        cyc++;
    endtask

    task automatic clear_logs();
        cyc = 0;
        q_pop.delete(); q_done.delete(); q_rdaddr.delete();
        q_rdcyc.delete(); q_beat.delete(); q_bcyc.delete();
        issued = 0; accepted = 0; maxout = 0; stall_err = 0;
        prev_stall = 1'b0;
    endtask

    task automatic run(input int ndone, input int budget);
        int n;
        n = 0;
        while (q_done.size() < ndone && n < budget) begin
            tick();
            n++;
        end
        if (q_done.size() < ndone) chk("timeout_rddone", q_done.size(), ndone);
        repeat (3) tick();
    endtask

    task automatic check_event(input string tag, input int start, input int len, input bit timed);
        int a;
        chk({tag, ".pops"}, q_pop.size(), 1);
        if (q_pop.size() > 0) chk({tag, ".pop_cyc"}, q_pop[0], 0);
        chk({tag, ".n_reads"}, q_rdaddr.size(), len);
        chk({tag, ".n_beats"}, q_beat.size(), len);
        for (int i = 0; i < len; i++) begin
            a = (start + i) % DEPTH;
            if (i < q_rdaddr.size()) begin
                chk({tag, ".rd_addr"}, q_rdaddr[i], a);
                if (timed) chk({tag, ".rd_cyc"}, q_rdcyc[i], 1 + i);
            end
            if (i < q_beat.size()) begin
                chk({tag, ".beat"}, q_beat[i], int'({(i == 0), (i == len - 1), ramf(a)}));
                if (timed) chk({tag, ".beat_cyc"}, q_bcyc[i], 2 + i);
            end
        end
        chk({tag, ".n_rddone"}, q_done.size(), 1);
        if (timed && q_done.size() > 0) chk({tag, ".rddone_cyc"}, q_done[0], 2 + len);
        chk({tag, ".outstanding_le2"}, int'(maxout <= 2), 1);
        chk({tag, ".stall_stable"}, stall_err, 0);
        chk({tag, ".busy_after"}, int'(busy_now), 0);
    endtask

    task automatic one_event(input string tag, input int start, input int stop, input int len,
                             input bit rnd, input int budget);
        clear_logs();
        ready_rand = rnd;
        hq_start.push_back(start);
        hq_stop.push_back(stop);
        rd_req = 1'b1;
        run(1, budget);
        rd_req = 1'b0;
        ready_rand = 1'b0;
        check_event(tag, start, len, !rnd);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached before the summary, expected completion");
        $fatal(1);
    end

    initial begin
        // Reset state
        clear_logs();
        force_rst = 1'b1;
        repeat (3) tick();
        force_rst = 1'b0;
        tick();
        chk("reset.flags", out_flags(), 0);
        chk("reset.rd_addr", int'(wvb_rd_addr), 0);
        chk("reset.dout", int'(dout), 0);

        one_event("basic", 10, 13, 4, 1'b0, 50);
        one_event("wrap", 4094, 1, 4, 1'b0, 50);
        one_event("single", 7, 7, 1, 1'b0, 50);
        one_event("full", 5, 4, 4096, 1'b0, 5000);
        one_event("random_ready", 0, 15, 16, 1'b1, 300);

        // Two queued headers, rd_req held: back-to-back events, then idle.
        clear_logs();
        hq_start.push_back(20); hq_stop.push_back(22);
        hq_start.push_back(30); hq_stop.push_back(31);
        rd_req = 1'b1;
        run(2, 100);
        repeat (3) tick();
        chk("two_hdr.n_pops", q_pop.size(), 2);
        chk("two_hdr.n_rddone", q_done.size(), 2);
        if (q_pop.size() == 2 && q_done.size() == 2) begin
            chk("two_hdr.pop0_cyc", q_pop[0], 0);
            chk("two_hdr.rddone0_cyc", q_done[0], 5);
            chk("two_hdr.pop1_cyc", q_pop[1], 6);
            chk("two_hdr.rddone1_cyc", q_done[1], 10);
        end
        chk("two_hdr.n_beats", q_beat.size(), 5);
        for (int i = 0; i < 5 && i < q_beat.size(); i++) begin
            int a;
            a = (i < 3) ? 20 + i : 27 + i;
            chk("two_hdr.beat", q_beat[i], int'({(i == 0 || i == 3), (i == 2 || i == 4), ramf(a)}));
        end
        chk("two_hdr.busy_idle", int'(busy_now), 0);
        rd_req = 1'b0;

        // Reset during beat 3 of an 8-word event (beats at cycles 2,3,4 -> reset in cycle 4).
        clear_logs();
        hq_start.push_back(100); hq_stop.push_back(107);
        rd_req = 1'b1;
        rst_at = 4;
        repeat (6) tick();
        chk("rst_mid.flags", out_flags(), 0);
        chk("rst_mid.rd_addr", int'(wvb_rd_addr), 0);
        chk("rst_mid.dout", int'(dout), 0);
        chk("rst_mid.beats_at_rst", q_beat.size(), 3);
        repeat (15) tick();
        chk("rst_mid.beats_after", q_beat.size(), 3);
        chk("rst_mid.n_rddone", q_done.size(), 0);
        chk("rst_mid.busy", int'(busy_now), 0);
        rst_at = -1;
        rd_req = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
